// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and op-class helper for the iterative ALU.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_SRL  = 5'b01010;
    localparam logic [4:0] ALU_SRA  = 5'b01011;
    localparam logic [4:0] ALU_SLL  = 5'b01101;
    localparam logic [4:0] ALU_BEQ  = 5'b10000;
    localparam logic [4:0] ALU_BNE  = 5'b10001;
    localparam logic [4:0] ALU_BLT  = 5'b10010;
    localparam logic [4:0] ALU_BGE  = 5'b10011;
    localparam logic [4:0] ALU_BLTU = 5'b10100;
    localparam logic [4:0] ALU_BGEU = 5'b10101;
    localparam logic [4:0] ALU_SLT  = 5'b10110;
    localparam logic [4:0] ALU_SLTU = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Unknown (X/Z) codes fall to the default and are treated as non-shift.
    function automatic logic is_shift_op(input logic [4:0] op);
        logic res;
        res = 1'b0;
        case (op)
            ALU_SRL, ALU_SRA, ALU_SLL: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: arithmetic, logic, compares, branch conditions and op legality.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            branch_cond,
    output logic            illegal_op
);

    logic lt_s;
    logic lt_u;
    logic eq;

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;
    assign eq   = a == b;

    always_comb begin
        result      = '0;
        branch_cond = 1'b0;
        illegal_op  = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            // Shifts are legal but iterated by the top level.
            ALU_SRL, ALU_SRA, ALU_SLL: result = '0;
            ALU_BEQ:  begin result = {{(XLEN-1){1'b0}}, eq};    branch_cond = eq;    end
            ALU_BNE:  begin result = {{(XLEN-1){1'b0}}, !eq};   branch_cond = !eq;   end
            ALU_BLT:  begin result = {{(XLEN-1){1'b0}}, lt_s};  branch_cond = lt_s;  end
            ALU_BGE:  begin result = {{(XLEN-1){1'b0}}, !lt_s}; branch_cond = !lt_s; end
            ALU_BLTU: begin result = {{(XLEN-1){1'b0}}, lt_u};  branch_cond = lt_u;  end
            ALU_BGEU: begin result = {{(XLEN-1){1'b0}}, !lt_u}; branch_cond = !lt_u; end
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            default:  illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/iterative_alu.sv
// Execute-stage ALU with valid/ready handshake; shifts iterate one bit per cycle.
//   state    | meaning
//   ST_IDLE  | ready for a new op; single-cycle ops resolve here
//   ST_SHIFT | accumulator shifting, counter counting down to 1
//   ST_DONE  | result held with out_valid until out_ready
module iterative_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_cond,
    output logic            illegal_op
);

    localparam int SHW = $clog2(XLEN);

    state_t          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            branch_q, branch_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] core_result;
    logic            core_branch;
    logic            core_illegal;
    logic [XLEN-1:0] acc_shifted;
    logic [SHW-1:0]  shamt;

    assign shamt = b[SHW-1:0];

    alu_comb_core #(.XLEN(XLEN)) u_core (
        .op          (alu_op),
        .a           (a),
        .b           (b),
        .result      (core_result),
        .branch_cond (core_branch),
        .illegal_op  (core_illegal)
    );

    always_comb begin
        acc_shifted = acc_q;
        case (op_q)
            ALU_SLL: acc_shifted = {acc_q[XLEN-2:0], 1'b0};
            ALU_SRL: acc_shifted = {1'b0, acc_q[XLEN-1:1]};
            ALU_SRA: acc_shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_shifted = acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift_op(alu_op) && (shamt != '0)) begin
                        op_d    = alu_op;
                        acc_d   = a;
                        cnt_d   = shamt;
                        state_d = ST_SHIFT;
                    end else begin
                        // A zero-distance shift passes operand A straight through.
                        result_d  = is_shift_op(alu_op) ? a : core_result;
                        branch_d  = core_branch;
                        illegal_d = core_illegal;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shifted;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    result_d  = acc_shifted;
                    branch_d  = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= ALU_ADD;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign result      = result_q;
    assign branch_cond = branch_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed plus randomized checks of iterative_alu against a plain-arithmetic reference model.
module tb_iterative_alu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        branch_cond;
    logic        illegal_op;

    int tests;
    int fails;

    iterative_alu #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .branch_cond (branch_cond),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_shift(input logic [4:0] op);
        return (op == 5'd10) || (op == 5'd11) || (op == 5'd13);
    endfunction

    // Reference: what each op means arithmetically, independent of how the DUT gets there.
    task automatic ref_model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] r, output logic br, output logic il);
        int sh;
        logic c;
        sh = int'(y[4:0]);
        r  = 32'd0;
        br = 1'b0;
        il = 1'b0;
        c  = 1'b0;
        case (op)
            5'd0:  r = x + y;
            5'd1:  r = x - y;
            5'd2:  r = x & y;
            5'd3:  r = x | y;
            5'd6:  r = x ^ y;
            5'd10: r = x >> sh;
            5'd11: r = 32'($signed(x) >>> sh);
            5'd13: r = x << sh;
            5'd16: begin c = (x == y);                  r = {31'd0, c}; br = c; end
            5'd17: begin c = (x != y);                  r = {31'd0, c}; br = c; end
            5'd18: begin c = ($signed(x) < $signed(y));  r = {31'd0, c}; br = c; end
            5'd19: begin c = ($signed(x) >= $signed(y)); r = {31'd0, c}; br = c; end
            5'd20: begin c = (x < y);                   r = {31'd0, c}; br = c; end
            5'd21: begin c = (x >= y);                  r = {31'd0, c}; br = c; end
            5'd22: r = {31'd0, ($signed(x) < $signed(y))};
            5'd23: r = {31'd0, (x < y)};
            default: il = 1'b1;
        endcase
    endtask

    // Issue one op, measure latency, check outputs, optionally stall the consumer, then drain.
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] x,
                          input logic [31:0] y, input int hold);
        logic [31:0] er;
        logic        eb;
        logic        ei;
        int          elat;
        int          lat;
        int          w;
        ref_model(op, x, y, er, eb, ei);
        elat = is_shift(op) ? 1 + int'(y[4:0]) : 1;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({name, ":in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        alu_op   = op;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op   = 5'($urandom);
        a        = $urandom;
        b        = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) chk({name, ":busy_in_ready"}, {31'd0, in_ready}, 32'd0);
        end while (!out_valid && lat < 40);
        chk({name, ":latency"}, 32'(lat), 32'(elat));
        chk({name, ":result"}, result, er);
        chk({name, ":branch_cond"}, {31'd0, branch_cond}, {31'd0, eb});
        chk({name, ":illegal_op"}, {31'd0, illegal_op}, {31'd0, ei});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, ":hold_result"}, result, er);
            chk({name, ":hold_out_valid"}, {31'd0, out_valid}, 32'd1);
            chk({name, ":hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        chk({name, ":in_ready_during_take"}, {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ":out_valid_after_take"}, {31'd0, out_valid}, 32'd0);
        chk({name, ":in_ready_after_take"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [4:0] legal_ops [16];
    logic [4:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        legal_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd10, 5'd11, 5'd13,
                      5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 5'd0;
        a         = 32'd0;
        b         = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset:out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset:result", result, 32'd0);
        chk("reset:branch_cond", {31'd0, branch_cond}, 32'd0);
        chk("reset:illegal_op", {31'd0, illegal_op}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset:in_ready", {31'd0, in_ready}, 32'd1);

        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stray_out_ready:out_valid", {31'd0, out_valid}, 32'd0);
        chk("stray_out_ready:in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sra_31", 5'd11, 32'h8000_0000, 32'd31, 0);
        run_op("blt_neg", 5'd18, 32'hFFFF_FFFE, 32'd1, 0);
        run_op("bltu_neg", 5'd20, 32'hFFFF_FFFE, 32'd1, 0);
        run_op("sll_zero", 5'd13, 32'd1, 32'd0, 5);
        run_op("illegal", 5'b11111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op("slt_sign", 5'd22, 32'h8000_0000, 32'd0, 0);
        run_op("srl_1", 5'd10, 32'h8000_0001, 32'd1, 2);

        // Abort an in-flight shift with reset; previous result (1) must be cleared.
        run_op("bne_prev", 5'd17, 32'd5, 32'd6, 0);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = 5'd10;
        a        = 32'hF000_0000;
        b        = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort:busy_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort:out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort:result", result, 32'd0);
        chk("abort:in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) chk("abort:late_out_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op("add_after_abort", 5'd0, 32'd3, 32'd4, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(7) == 0) rop = 5'($urandom);
            else                        rop = legal_ops[$urandom_range(15)];
            ra = $urandom;
            rb = ($urandom_range(3) == 0) ? ra : $urandom;
            run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, int'($urandom_range(2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
